// File: rtl/wbclint_pkg.sv
// Shared constants and helpers for the wbclint timer/interrupt controller.
// Register offsets are word offsets decoded from wb_adr_i[2:0].
package wbclint_pkg;

    localparam logic [2:0] REG_MSIP        = 3'd0;
    localparam logic [2:0] REG_MTIMECMP_LO = 3'd1;
    localparam logic [2:0] REG_MTIMECMP_HI = 3'd2;
    localparam logic [2:0] REG_MTIME_LO    = 3'd3;
    localparam logic [2:0] REG_MTIME_HI    = 3'd4;
    localparam logic [2:0] REG_PRESCALE    = 3'd5;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        for (int i = 0; i < 4; i++)
            res[i*8 +: 8] = sel[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
        return res;
    endfunction

endpackage

// File: rtl/wbclint_prescaler.sv
// Tick prescaler: counts 0..period_m1 and pulses tick on the wrap cycle.
// clear restarts the count from 0 at the next edge.
module wbclint_prescaler (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] period_m1,
    input  logic        clear,
    output logic        tick
);

    logic [15:0] cnt;

    // >= keeps the counter from running away if the period ever shrinks under it
    assign tick = (cnt >= period_m1);

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (clear || tick)
            cnt <= '0;
        else
            cnt <= cnt + 16'd1;
    end

endmodule

// File: rtl/wbclint.sv
// Wishbone CLINT-style timer: 64-bit mtime/mtimecmp, msip, timer and software irqs.
// Optional runtime-programmable tick period under `define WBCLINT_PRESCALER_EN.
module wbclint
    import wbclint_pkg::*;
#(
    parameter int AW      = 30,
    parameter int DW      = 32,
    parameter int CLK_DIV = 48
) (
    input  logic            wb_clk_i,
    input  logic            wb_reset_i,
    input  logic [AW-1:0]   wb_adr_i,
    input  logic [DW-1:0]   wb_dat_i,
    output logic [DW-1:0]   wb_dat_o,
    input  logic            wb_we_i,
    input  logic [DW/8-1:0] wb_sel_i,
    input  logic            wb_cyc_i,
    input  logic            wb_stb_i,
    output logic            wb_ack_o,
    output logic            timer_irq_o,
    output logic            soft_irq_o
);

    localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);

    logic        acc, wr, sel_any, mtime_wr, tick, presc_clr;
    logic [2:0]  adr;
    logic [15:0] period_m1;
    logic        ack_q, msip, timer_q, soft_q;
    logic [31:0] dat_q, shadow, rdata;
    logic [63:0] mtime, mtimecmp;
    logic        unused_adr;

    assign acc      = wb_cyc_i & wb_stb_i;
    assign wr       = acc & wb_we_i;
    assign adr      = wb_adr_i[2:0];
    assign sel_any  = |wb_sel_i;
    assign mtime_wr = wr && sel_any && (adr == REG_MTIME_LO || adr == REG_MTIME_HI);
    assign unused_adr = ^wb_adr_i[AW-1:3];

`ifdef WBCLINT_PRESCALER_EN
    logic [15:0] prescale;
    logic [31:0] prescale_new;

    assign prescale_new = merge_bytes({16'h0, prescale}, wb_dat_i, wb_sel_i);
    assign period_m1    = prescale;
    assign presc_clr    = wr && (adr == REG_PRESCALE) && (|wb_sel_i[1:0]);

    always_ff @(posedge wb_clk_i) begin
        if (wb_reset_i)
            prescale <= DIV_M1;
        else if (presc_clr)
            prescale <= prescale_new[15:0];
    end
`else
    assign period_m1 = DIV_M1;
    assign presc_clr = 1'b0;
`endif

    wbclint_prescaler u_prescaler (
        .clk       (wb_clk_i),
        .rst       (wb_reset_i),
        .period_m1 (period_m1),
        .clear     (presc_clr),
        .tick      (tick)
    );

    always_comb begin
        rdata = '0;
        case (adr)
            REG_MSIP:        rdata[0] = msip;
            REG_MTIMECMP_LO: rdata = mtimecmp[31:0];
            REG_MTIMECMP_HI: rdata = mtimecmp[63:32];
            REG_MTIME_LO:    rdata = mtime[31:0];
            REG_MTIME_HI:    rdata = shadow;
`ifdef WBCLINT_PRESCALER_EN
            REG_PRESCALE:    rdata[15:0] = prescale;
`endif
            default:         rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_reset_i) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            shadow   <= '0;
            msip     <= 1'b0;
            mtime    <= '0;
            mtimecmp <= MTIMECMP_RST;
            timer_q  <= 1'b0;
            soft_q   <= 1'b0;
        end else begin
            ack_q   <= acc;
            timer_q <= (mtime >= mtimecmp);
            soft_q  <= msip;
            if (acc)
                dat_q <= rdata;
            // HI reads return this snapshot so a LO-then-HI pair is coherent
            if (acc && !wb_we_i && adr == REG_MTIME_LO)
                shadow <= mtime[63:32];
            if (wr && adr == REG_MSIP && wb_sel_i[0])
                msip <= wb_dat_i[0];
            if (wr && adr == REG_MTIMECMP_LO)
                mtimecmp[31:0] <= merge_bytes(mtimecmp[31:0], wb_dat_i, wb_sel_i);
            if (wr && adr == REG_MTIMECMP_HI)
                mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], wb_dat_i, wb_sel_i);
            // a software write suppresses that cycle's increment entirely
            if (mtime_wr) begin
                if (adr == REG_MTIME_LO)
                    mtime[31:0] <= merge_bytes(mtime[31:0], wb_dat_i, wb_sel_i);
                else
                    mtime[63:32] <= merge_bytes(mtime[63:32], wb_dat_i, wb_sel_i);
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end
        end
    end

    assign wb_ack_o    = ack_q & wb_cyc_i & ~wb_reset_i;
    assign wb_dat_o    = dat_q;
    assign timer_irq_o = timer_q;
    assign soft_irq_o  = soft_q;

endmodule
